// File: rtl/eth_frame_builder_if.sv
`default_nettype none
// ============================================================================
// eth_frame_builder_if : payload stream, transmitter handshake and BRAM write port
// Revision 1.0
// ============================================================================
interface eth_frame_builder_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        tx_start;
    logic        tx_busy;
    logic        bram_wr_en;
    logic [9:0]  bram_wr_addr;
    logic [7:0]  bram_wr_data;
    logic [15:0] frame_count;

    modport master (
        input  s_data, s_valid, tx_busy,
        output s_ready, tx_start, bram_wr_en, bram_wr_addr, bram_wr_data, frame_count
    );

    modport slave (
        output s_data, s_valid, tx_busy,
        input  s_ready, tx_start, bram_wr_en, bram_wr_addr, bram_wr_data, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/eth_frame_builder.sv
`default_nettype none
// ============================================================================
// eth_frame_builder : writes a 512-byte Ethernet/IPv4/UDP frame into the tx BRAM
// Revision 1.0
// ============================================================================
module eth_frame_builder #(
    parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC  = 48'h020000000001,
    parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
    parameter logic [31:0] DST_IP   = 32'hC0A801FF,
    parameter logic [15:0] SRC_PORT = 16'd1234,
    parameter logic [15:0] DST_PORT = 16'd1234,
    parameter logic [7:0]  TTL      = 8'd64
) (
    input  wire logic            clk,
    input  wire logic            rst,
    eth_frame_builder_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CSUM    = 3'd1,
        HDR     = 3'd2,
        PAYLOAD = 3'd3,
        KICK    = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] acc;
    logic [15:0] csum;
    logic [3:0]  word_idx;

    logic [15:0] csum_word;
    logic [16:0] sum17;
    logic [15:0] acc_next;
    logic [335:0] hdr_vec;
    logic [5:0]  hdr_idx;
    logic [5:0]  hdr_pos;
    logic [7:0]  hdr_byte;

    always_comb begin
        csum_word = 16'h0000;
        case (word_idx)
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = 16'h01F2;
            4'd2:    csum_word = bus.frame_count;
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {TTL, 8'h11};
            4'd5:    csum_word = 16'h0000;
            4'd6:    csum_word = SRC_IP[31:16];
            4'd7:    csum_word = SRC_IP[15:0];
            4'd8:    csum_word = DST_IP[31:16];
            4'd9:    csum_word = DST_IP[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    // One's-complement add with end-around carry; the result never exceeds 16 bits.
    assign sum17    = {1'b0, acc} + {1'b0, csum_word};
    assign acc_next = sum17[15:0] + {15'd0, sum17[16]};

    assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800,
                      32'h450001F2, bus.frame_count, 16'h4000, TTL, 8'h11, csum,
                      SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, 16'h01DE, 16'h0000};

    // Byte for the address about to be presented: 0 on HDR entry, else current+1.
    assign hdr_idx  = (state == HDR) ? (bus.bram_wr_addr[5:0] + 6'd1) : 6'd0;
    assign hdr_pos  = 6'd41 - hdr_idx;
    assign hdr_byte = hdr_vec[{hdr_pos, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            acc              <= 16'h0000;
            csum             <= 16'h0000;
            word_idx         <= 4'd0;
            bus.s_ready      <= 1'b0;
            bus.tx_start     <= 1'b0;
            bus.bram_wr_en   <= 1'b0;
            bus.bram_wr_addr <= 10'd0;
            bus.bram_wr_data <= 8'h00;
            bus.frame_count  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.tx_busy) begin
                        state    <= CSUM;
                        acc      <= 16'h0000;
                        word_idx <= 4'd0;
                    end
                end
                CSUM: begin
                    acc      <= acc_next;
                    word_idx <= word_idx + 4'd1;
                    if (word_idx == 4'd9) begin
                        csum             <= ~acc_next;
                        state            <= HDR;
                        bus.bram_wr_en   <= 1'b1;
                        bus.bram_wr_addr <= 10'd0;
                        bus.bram_wr_data <= hdr_byte;
                    end
                end
                HDR: begin
                    if (bus.bram_wr_addr[5:0] == 6'd41) begin
                        state          <= PAYLOAD;
                        bus.bram_wr_en <= 1'b0;
                        bus.s_ready    <= 1'b1;
                    end else begin
                        bus.bram_wr_addr <= bus.bram_wr_addr + 10'd1;
                        bus.bram_wr_data <= hdr_byte;
                    end
                end
                PAYLOAD: begin
                    bus.bram_wr_en <= bus.s_valid & bus.s_ready;
                    if (bus.s_valid && bus.s_ready) begin
                        bus.bram_wr_addr <= bus.bram_wr_addr + 10'd1;
                        bus.bram_wr_data <= bus.s_data;
                        if (bus.bram_wr_addr == 10'd510) begin
                            bus.s_ready  <= 1'b0;
                            bus.tx_start <= 1'b1;
                            state        <= KICK;
                        end
                    end
                end
                KICK: begin
                    // Held high until seen: the transmitter samples start only on its enable.
                    bus.bram_wr_en <= 1'b0;
                    if (bus.tx_busy) begin
                        bus.tx_start    <= 1'b0;
                        bus.frame_count <= bus.frame_count + 16'd1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/eth_frame_builder.md
# eth_frame_builder

Upstream neighbour of the 10BASE-T transmitter. Assembles one 512-byte Ethernet/IPv4/UDP frame into the transmitter's frame BRAM: 42 header bytes with a live IPv4 header checksum, then 470 payload bytes taken from a byte stream. It then requests transmission and waits for the transmitter to accept the frame. The BRAM is never written while the transmitter is busy.

## Interface
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC
- SRC_MAC, 48'h020000000001, source MAC
- SRC_IP, 32'hC0A8010A, IPv4 source
- DST_IP, 32'hC0A801FF, IPv4 destination
- SRC_PORT, 16'd1234, UDP source port
- DST_PORT, 16'd1234, UDP destination port
- TTL, 8'd64, IPv4 TTL
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_ready  out  1  payload byte accepted when s_valid & s_ready
- tx_start  out  1  frame-ready request to transmitter `start`
- tx_busy  in  1  transmitter busy
- bram_wr_en  out  1  BRAM write strobe
- bram_wr_addr  out  10  BRAM byte address
- bram_wr_data  out  8  BRAM write byte
- frame_count  out  16  frames handed off; also the IPv4 identification of the next frame

## Operation
- States: IDLE, CSUM, HDR, PAYLOAD, KICK.
- IDLE: if tx_busy=0, go to CSUM and clear the accumulator and word index.
- CSUM: takes 10 cycles, one 16-bit word per cycle.
  - Words: 16'h4500, 16'h01F2 (total length 498), frame_count, 16'h4000 (DF), {TTL,8'h11}, 16'h0000, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0].
  - Per cycle: sum17 = acc + word; acc <= sum17[15:0] + sum17[16] (end-around carry, so acc always fits 16 bits).
  - After word 9: csum <= ~acc, go to HDR.
- HDR: writes addresses 0..41, one byte per cycle, big-endian.
  - 0-5 DST_MAC; 6-11 SRC_MAC; 12-13 08 00.
  - 14-33 IPv4 header: 45 00 01 F2, ident(frame_count), 40 00, TTL 11, csum, SRC_IP, DST_IP.
  - 34-41 UDP header: SRC_PORT, DST_PORT, 01 DE (length 478), 00 00 (checksum disabled).
  - After address 41, go to PAYLOAD.
- PAYLOAD: s_ready=1. Each handshake writes s_data to the next address, 42..511.
  - When s_valid=0, bram_wr_en=0 and the address holds.
  - After the write to 511, go to KICK.
- KICK: tx_start=1 until tx_busy=1 is sampled. Then frame_count <= frame_count+1 (wraps 16'hFFFF->0) and return to IDLE.
  - tx_start is level-held because the transmitter samples it only on its clock enable.
- s_ready=0 in every state except PAYLOAD.
- tx_busy is read only in IDLE and KICK.

## Timing
- Reset: state IDLE, s_ready=0, tx_start=0, bram_wr_en=0, bram_wr_addr=0, bram_wr_data=0, frame_count=0, acc=0.
- All outputs are registered. A write strobe asserts with its address and data on the same cycle.
- IDLE->CSUM takes 1 cycle after tx_busy=0 is sampled. CSUM lasts exactly 10 cycles. HDR lasts exactly 42 cycles with bram_wr_en continuously high.
- Payload throughput: 1 byte/cycle with s_valid held high. Minimum frame-build time is 1+10+42+470 cycles plus the KICK handshake.
- s_ready drops on the cycle after the 470th handshake is accepted. No byte is accepted outside PAYLOAD.
- tx_busy=1 in IDLE holds IDLE indefinitely with no writes.
- If tx_busy is already 1 on KICK entry, tx_start is high for exactly 1 cycle.
- rst=1 mid-frame (any state) returns to IDLE next cycle. The partial frame is abandoned, frame_count is cleared, and there is no tx_start.
- bram_wr_addr never exceeds 511. Address bit 9 is set only for 512..1023, which is never written.

## Test plan
- Default parameters, frame_count=0, payload bytes 00..D5 (470 bytes, continuous valid) -> BRAM[24:25]=B4 A1, BRAM[12:13]=08 00, BRAM[16:17]=01 F2, BRAM[38:39]=01 DE, BRAM[42]=00, BRAM[511]=D5; tx_start rises once.
- Second frame: ident=0001 -> BRAM[18:19]=00 01, BRAM[24:25]=B4 A0; frame_count=2 after handoff.
- Random s_valid gaps (50% duty) -> no writes during gaps, addresses contiguous 42..511, exactly 470 handshakes.
- tx_busy held 1 for 1000 cycles after reset -> stays IDLE, bram_wr_en never asserts. Then tx_busy=0 -> CSUM starts the next cycle.
- KICK with tx_busy delayed 37 cycles -> tx_start high exactly 37 cycles, frame_count increments once.
- rst asserted at payload byte 100 -> next cycle all outputs at reset values. The next frame starts from address 0 with ident 0000.
